uni_arb2: RTL and testbench

- Two-requester to one-slave arbiter for the unified memory bus (uni_if).
- Shares one downstream memory/AXI-bridge port between the IFU (m0) and the LSU (m1).
- Owner is registered; the owner's request is forwarded unchanged until the downstream completes the transfer with ready.
- Sits between the cache/fetch front ends and the single memory port.

---
 rtl/uni_arb2_pkg.sv | 32 +++
 rtl/uni_arb2_if.sv | 27 ++
 rtl/uni_arb2_pick.sv | 32 +++
 rtl/uni_arb2.sv | 183 ++++++++++++++++++
 tb/tb_uni_arb2.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uni_arb2_pkg.sv
// Shared types and constants for the two-way unified-bus arbiter.
package uni_arb_pkg;

    // Arbiter state; the owner of the downstream port is encoded in the state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_e;

    // Requester identifiers, also used as the last-grant record.
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Request type encoding on the reqtyp field.
    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    // True when the given state means requester 'id' owns the downstream port.
    function automatic logic state_owned_by(input arb_state_e st, input logic id);
        logic owned;
        owned = 1'b0;
        case (st)
            BUSY0:   owned = (id == OWNER_M0);
            BUSY1:   owned = (id == OWNER_M1);
            IDLE:    owned = 1'b0;
            default: owned = 1'b0;
        endcase
        return owned;
    endfunction

endpackage

// File: rtl/uni_arb2_if.sv
// Unified memory bus: requester-side request fields plus ready/rdata return.
// A requester holds all request fields stable until it sees ready for one cycle.
interface uni_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              reqtyp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              cachable;
    logic [1:0]        size;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    // Side that issues requests.
    modport Master (
        output valid, reqtyp, addr, wdata, cachable, size,
        input  ready, rdata
    );

    // Side that services requests.
    modport Slave (
        input  valid, reqtyp, addr, wdata, cachable, size,
        output ready, rdata
    );
endinterface

// File: rtl/uni_arb2_pick.sv
// Combinational two-way picker: chooses between two requests given the last
// grant. FIXED_PRIO = 0 alternates on ties, FIXED_PRIO = 1 lets req1 win ties.
module uni_arb_pick
    import uni_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    // Winner selection; a lone requester always wins regardless of history.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = OWNER_M0;
        if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
                gnt_id = OWNER_M1;
            end else begin
                gnt_id = ~last_gnt;
            end
        end else if (req1) begin
            gnt_id = OWNER_M1;
        end else begin
            gnt_id = OWNER_M0;
        end
    end

endmodule

// File: rtl/uni_arb2.sv
// uni_arb2: shares one downstream uni_if port between the IFU (m0) and LSU (m1).
// The owner is registered in the state; its request is forwarded unchanged
// until the downstream answers with ready, after which the arbiter returns to
// IDLE for one bubble cycle before the next grant.
// Optional build macro UNI_ARB_PERF_EN adds 64-bit grant/wait counters.
module uni_arb2
    import uni_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic  i_clk,
    input  logic  i_rst,
    uni_if.Slave  m0,
    uni_if.Slave  m1,
    uni_if.Master s
`ifdef UNI_ARB_PERF_EN
    ,
    output logic [63:0] o_gnt_cnt0,
    output logic [63:0] o_gnt_cnt1,
    output logic [63:0] o_wait_cnt
`endif
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       last_gnt_r;
    logic       last_gnt_nxt_s;
    logic       gnt_valid_s;
    logic       gnt_id_s;

    // Requests are only sampled while IDLE; the picker sees raw valids.
    uni_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req0      (m0.valid),
        .req1      (m1.valid),
        .last_gnt  (last_gnt_r),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // State and last-grant registers; reset leaves m1 as last so m0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= IDLE;
            last_gnt_r <= OWNER_M1;
        end else begin
            state_r    <= state_nxt_s;
            last_gnt_r <= last_gnt_nxt_s;
        end
    end

    // Next-state logic; an owner that drops valid early keeps the port until ready.
    always_comb begin
        state_nxt_s    = state_r;
        last_gnt_nxt_s = last_gnt_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    if (gnt_id_s == OWNER_M1) begin
                        state_nxt_s = BUSY1;
                    end else begin
                        state_nxt_s = BUSY0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY0: begin
                if (s.ready) begin
                    state_nxt_s    = IDLE;
                    last_gnt_nxt_s = OWNER_M0;
                end else begin
                    state_nxt_s = BUSY0;
                end
            end
            BUSY1: begin
                if (s.ready) begin
                    state_nxt_s    = IDLE;
                    last_gnt_nxt_s = OWNER_M1;
                end else begin
                    state_nxt_s = BUSY1;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                last_gnt_nxt_s = OWNER_M1;
            end
        endcase
    end

    // Request/response steering: the owner is wired straight through, everyone else sees zeros.
    always_comb begin
        s.valid    = 1'b0;
        s.reqtyp   = REQ_RD;
        s.addr     = {ADDR_W{1'b0}};
        s.wdata    = {DATA_W{1'b0}};
        s.cachable = 1'b0;
        s.size     = 2'b00;
        m0.ready   = 1'b0;
        m0.rdata   = {DATA_W{1'b0}};
        m1.ready   = 1'b0;
        m1.rdata   = {DATA_W{1'b0}};
        case (state_r)
            BUSY0: begin
                s.valid    = m0.valid;
                s.reqtyp   = m0.reqtyp;
                s.addr     = m0.addr;
                s.wdata    = m0.wdata;
                s.cachable = m0.cachable;
                s.size     = m0.size;
                m0.ready   = s.ready;
                m0.rdata   = s.rdata;
            end
            BUSY1: begin
                s.valid    = m1.valid;
                s.reqtyp   = m1.reqtyp;
                s.addr     = m1.addr;
                s.wdata    = m1.wdata;
                s.cachable = m1.cachable;
                s.size     = m1.size;
                m1.ready   = s.ready;
                m1.rdata   = s.rdata;
            end
            IDLE: begin
                s.valid = 1'b0;
            end
            default: begin
                s.valid = 1'b0;
            end
        endcase
    end

`ifdef UNI_ARB_PERF_EN
    logic [63:0] gnt_cnt0_r;
    logic [63:0] gnt_cnt1_r;
    logic [63:0] wait_cnt_r;
    logic        m0_done_s;
    logic        m1_done_s;
    logic        waiting_s;

    // Completion and wait qualifiers; the wait counter steps once per cycle in
    // which at least one requester is held off (IDLE counts as not owning).
    always_comb begin
        m0_done_s = state_owned_by(state_r, OWNER_M0) && s.ready;
        m1_done_s = state_owned_by(state_r, OWNER_M1) && s.ready;
        waiting_s = (m0.valid && !state_owned_by(state_r, OWNER_M0)) ||
                    (m1.valid && !state_owned_by(state_r, OWNER_M1));
    end

    // Free-running performance counters, wrapping modulo 2^64.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_cnt0_r <= 64'd0;
            gnt_cnt1_r <= 64'd0;
            wait_cnt_r <= 64'd0;
        end else begin
            if (m0_done_s) begin
                gnt_cnt0_r <= gnt_cnt0_r + 64'd1;
            end else begin
                gnt_cnt0_r <= gnt_cnt0_r;
            end
            if (m1_done_s) begin
                gnt_cnt1_r <= gnt_cnt1_r + 64'd1;
            end else begin
                gnt_cnt1_r <= gnt_cnt1_r;
            end
            if (waiting_s) begin
                wait_cnt_r <= wait_cnt_r + 64'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    assign o_gnt_cnt0 = gnt_cnt0_r;
    assign o_gnt_cnt1 = gnt_cnt1_r;
    assign o_wait_cnt = wait_cnt_r;
`endif

endmodule

// File: tb/tb_uni_arb2.sv
// Scoreboard bench for uni_arb2: one instance per FIXED_PRIO setting, both fed
// the same requester traffic; the expected completion order per instance is
// pushed into a queue and a monitor pops it on every requester ready pulse.
module tb_uni_arb2;

    typedef struct packed {
        logic        typ;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        cach;
        logic [1:0]  size;
    } req_t;

    typedef struct packed {
        logic        port;
        req_t        r;
        logic [63:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    int   ds_lat;
    int   cmp_cnt;
    int   fail_cnt;

    req_t        rq_q[2][2][$];
    exp_t        exp_q[2][$];
    logic        sv_w[2];
    logic        mr_w[2][2];
    logic [63:0] mrd_w[2][2];
    logic [63:0] wcnt[2];
`ifdef UNI_ARB_PERF_EN
    logic [63:0] pc0_w[2];
    logic [63:0] pc1_w[2];
    logic [63:0] pcw_w[2];
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s dut%0d: got %h want %h", nm, g, act, exp);
        end
    endtask

    // Downstream memory model data: fixed pattern for one address, else {~addr, addr}.
    function automatic logic [63:0] ds_data(input logic [31:0] a);
        if (a == 32'h8000_0000) return 64'hDEAD_BEEF_0123_4567;
        return {~a, a};
    endfunction

    function automatic req_t mk(input logic t, input logic [31:0] a, input logic [63:0] wd,
                                input logic c, input logic [1:0] sz);
        req_t r;
        r.typ = t; r.addr = a; r.wdata = wd; r.cach = c; r.size = sz;
        return r;
    endfunction

    task automatic send(input int p, input req_t r);
        rq_q[0][p].push_back(r);
        rq_q[1][p].push_back(r);
    endtask

    task automatic exp_tr(input int g, input int p, input req_t r, input logic [63:0] rd);
        exp_t e;
        e.port = p[0]; e.r = r; e.rdata = rd;
        exp_q[g].push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int  n;
        bit  done;
        n = 0; done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                   (rq_q[0][0].size() == 0) && (rq_q[0][1].size() == 0) &&
                   (rq_q[1][0].size() == 0) && (rq_q[1][1].size() == 0);
        end
        cmp_cnt++;
        if (!done) begin
            fail_cnt++;
            $display("FAIL timeout_%s: transfers still pending after %0d cycles", nm, n);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        uni_if #(.ADDR_W(32), .DATA_W(64)) mi[2] ();
        uni_if #(.ADDR_W(32), .DATA_W(64)) si ();

        uni_arb2 #(.ADDR_W(32), .DATA_W(64), .FIXED_PRIO(g)) dut (
            .i_clk (clk),
            .i_rst (rst),
            .m0    (mi[0]),
            .m1    (mi[1]),
            .s     (si)
`ifdef UNI_ARB_PERF_EN
            ,
            .o_gnt_cnt0 (pc0_w[g]),
            .o_gnt_cnt1 (pc1_w[g]),
            .o_wait_cnt (pcw_w[g])
`endif
        );

        assign sv_w[g] = si.valid;

        for (genvar p = 0; p < 2; p++) begin : rp
            assign mr_w[g][p]  = mi[p].ready;
            assign mrd_w[g][p] = mi[p].rdata;

            // Requester: presents the queue head and holds it until ready is seen.
            initial begin : req
                req_t cur;
                bit   hold;
                bit   seen;
                hold = 1'b0; seen = 1'b0; cur = '0;
                mi[p].valid = 1'b0; mi[p].reqtyp = 1'b0; mi[p].addr = 32'd0;
                mi[p].wdata = 64'd0; mi[p].cachable = 1'b0; mi[p].size = 2'b00;
                forever begin
                    @(posedge clk); #2;
                    if (rst) begin
                        hold = 1'b0;
                        rq_q[g][p].delete();
                    end else begin
                        if (hold && seen) begin
                            void'(rq_q[g][p].pop_front());
                            hold = 1'b0;
                        end
                        if (!hold && rq_q[g][p].size() > 0) begin
                            cur  = rq_q[g][p][0];
                            hold = 1'b1;
                        end
                    end
                    mi[p].valid    = hold;
                    mi[p].reqtyp   = hold ? cur.typ : 1'b0;
                    mi[p].addr     = hold ? cur.addr : 32'd0;
                    mi[p].wdata    = hold ? cur.wdata : 64'd0;
                    mi[p].cachable = hold ? cur.cach : 1'b0;
                    mi[p].size     = hold ? cur.size : 2'b00;
                    @(negedge clk);
                    seen = mi[p].ready;
                end
            end
        end

        // Downstream: answers ready for one cycle ds_lat cycles after valid appears.
        initial begin : ds
            int cnt;
            cnt = 0; si.ready = 1'b0; si.rdata = 64'd0;
            forever begin
                @(posedge clk); #3;
                if (rst || !si.valid) begin
                    cnt = 0; si.ready = 1'b0; si.rdata = 64'd0;
                end else begin
                    cnt++;
                    if (cnt == ds_lat) begin
                        si.ready = 1'b1; si.rdata = ds_data(si.addr);
                    end else begin
                        si.ready = 1'b0; si.rdata = 64'd0;
                    end
                end
            end
        end

        // Monitor: every requester ready pulse must match the next expected completion.
        initial begin : mon
            exp_t e;
            forever begin
                @(negedge clk);
                for (int p = 0; p < 2; p++) begin
                    if (mr_w[g][p]) begin
                        if (exp_q[g].size() == 0) begin
                            cmp_cnt++; fail_cnt++;
                            $display("FAIL unexpected_ready dut%0d: got ready on port %0d want none", g, p);
                        end else begin
                            e = exp_q[g].pop_front();
                            chk("grant_port", g, 64'(p), 64'(e.port));
                            chk("rdata", g, mrd_w[g][p], e.rdata);
                            chk("s_addr", g, 64'(si.addr), 64'(e.r.addr));
                            chk("s_reqtyp", g, 64'(si.reqtyp), 64'(e.r.typ));
                            chk("s_wdata", g, si.wdata, e.r.wdata);
                            chk("s_size", g, 64'(si.size), 64'(e.r.size));
                            chk("s_cachable", g, 64'(si.cachable), 64'(e.r.cach));
                            chk("nonowner_ready", g, 64'(mr_w[g][1-p]), 64'd0);
                            chk("nonowner_rdata", g, mrd_w[g][1-p], 64'd0);
                        end
                    end
                end
            end
        end

        // Reference owner tracking used only to count cycles a requester is held off.
        initial begin : shadow
            int   sh;
            logic lg;
            sh = 0; lg = 1'b1; wcnt[g] = 64'd0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    sh = 0; lg = 1'b1; wcnt[g] = 64'd0;
                end else begin
                    if ((mi[0].valid && sh != 1) || (mi[1].valid && sh != 2)) wcnt[g] = wcnt[g] + 64'd1;
                    if (sh == 0) begin
                        if (mi[0].valid && mi[1].valid) sh = (g == 1) ? 2 : (lg ? 1 : 2);
                        else if (mi[0].valid) sh = 1;
                        else if (mi[1].valid) sh = 2;
                    end else if (si.ready) begin
                        lg = (sh == 2);
                        sh = 0;
                    end
                end
            end
        end
    end

    initial begin : stim
        req_t a0, a1, b0, b1, rb, dw, dr, ab, e0, e1, e2, f0, f1;
        cmp_cnt = 0; fail_cnt = 0;
        rst = 1'b1; ds_lat = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_s_valid", g, 64'(sv_w[g]), 64'd0);
            chk("rst_m0_ready", g, 64'(mr_w[g][0]), 64'd0);
            chk("rst_m1_ready", g, 64'(mr_w[g][1]), 64'd0);
`ifdef UNI_ARB_PERF_EN
            chk("rst_gnt_cnt0", g, pc0_w[g], 64'd0);
            chk("rst_wait_cnt", g, pcw_w[g], 64'd0);
`endif
        end
        @(posedge clk); #1; rst = 1'b0;

        // Contention from reset: round-robin alternates, fixed priority drains m1 first.
        @(posedge clk); #1;
        a0 = mk(1'b0, 32'h0000_0100, 64'd0, 1'b1, 2'b11);
        a1 = mk(1'b0, 32'h0000_0104, 64'd0, 1'b1, 2'b11);
        b0 = mk(1'b0, 32'h0000_0200, 64'd0, 1'b1, 2'b10);
        b1 = mk(1'b0, 32'h0000_0204, 64'd0, 1'b1, 2'b10);
        send(0, a0); send(0, a1); send(1, b0); send(1, b1);
        exp_tr(0, 0, a0, 64'hFFFF_FEFF_0000_0100);
        exp_tr(0, 1, b0, 64'hFFFF_FDFF_0000_0200);
        exp_tr(0, 0, a1, 64'hFFFF_FEFB_0000_0104);
        exp_tr(0, 1, b1, 64'hFFFF_FDFB_0000_0204);
        exp_tr(1, 1, b0, 64'hFFFF_FDFF_0000_0200);
        exp_tr(1, 1, b1, 64'hFFFF_FDFB_0000_0204);
        exp_tr(1, 0, a0, 64'hFFFF_FEFF_0000_0100);
        exp_tr(1, 0, a1, 64'hFFFF_FEFB_0000_0104);
        wait_idle("contention");

        // Single m0 read, ready on the third busy cycle; s.valid lags m0.valid by one cycle.
        ds_lat = 3;
        @(posedge clk); #1;
        rb = mk(1'b0, 32'h8000_0000, 64'd0, 1'b1, 2'b11);
        send(0, rb);
        exp_tr(0, 0, rb, 64'hDEAD_BEEF_0123_4567);
        exp_tr(1, 0, rb, 64'hDEAD_BEEF_0123_4567);
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("bubble_s_valid", g, 64'(sv_w[g]), 64'd0);
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("grant_s_valid", g, 64'(sv_w[g]), 64'd1);
        wait_idle("single_read");

        // m1 write alongside an m0 read: s must carry exactly the m1 fields first.
        ds_lat = 2;
        @(posedge clk); #1;
        dw = mk(1'b1, 32'h0000_1000, 64'h0000_0000_0000_55AA, 1'b0, 2'b01);
        dr = mk(1'b0, 32'h0000_2000, 64'd0, 1'b1, 2'b11);
        send(1, dw); send(0, dr);
        for (int g = 0; g < 2; g++) begin
            exp_tr(g, 1, dw, 64'hFFFF_EFFF_0000_1000);
            exp_tr(g, 0, dr, 64'hFFFF_DFFF_0000_2000);
        end
        wait_idle("write_vs_read");

        // Reset in the middle of an m0 transfer, then 3 m0 + 2 m1 with contention.
        ds_lat = 8;
        @(posedge clk); #1;
        ab = mk(1'b0, 32'h0000_3000, 64'd0, 1'b1, 2'b11);
        send(0, ab);
        @(negedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk("busy_before_rst", g, 64'(sv_w[g]), 64'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; ds_lat = 2;
        e0 = mk(1'b0, 32'h0000_0400, 64'd0, 1'b1, 2'b11);
        e1 = mk(1'b0, 32'h0000_0404, 64'd0, 1'b1, 2'b11);
        e2 = mk(1'b0, 32'h0000_0408, 64'd0, 1'b1, 2'b11);
        f0 = mk(1'b1, 32'h0000_0500, 64'h1111_2222_3333_4444, 1'b1, 2'b11);
        f1 = mk(1'b1, 32'h0000_0504, 64'h5555_6666_7777_8888, 1'b0, 2'b00);
        send(0, e0); send(0, e1); send(0, e2); send(1, f0); send(1, f1);
        exp_tr(0, 0, e0, 64'hFFFF_FBFF_0000_0400);
        exp_tr(0, 1, f0, 64'hFFFF_FAFF_0000_0500);
        exp_tr(0, 0, e1, 64'hFFFF_FBFB_0000_0404);
        exp_tr(0, 1, f1, 64'hFFFF_FAFB_0000_0504);
        exp_tr(0, 0, e2, 64'hFFFF_FBF7_0000_0408);
        exp_tr(1, 1, f0, 64'hFFFF_FAFF_0000_0500);
        exp_tr(1, 1, f1, 64'hFFFF_FAFB_0000_0504);
        exp_tr(1, 0, e0, 64'hFFFF_FBFF_0000_0400);
        exp_tr(1, 0, e1, 64'hFFFF_FBFB_0000_0404);
        exp_tr(1, 0, e2, 64'hFFFF_FBF7_0000_0408);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("post_rst_s_valid", g, 64'(sv_w[g]), 64'd0);
            chk("post_rst_m0_ready", g, 64'(mr_w[g][0]), 64'd0);
            chk("post_rst_m1_ready", g, 64'(mr_w[g][1]), 64'd0);
        end
        wait_idle("after_reset");
        repeat (2) @(negedge clk);
`ifdef UNI_ARB_PERF_EN
        for (int g = 0; g < 2; g++) begin
            chk("gnt_cnt0", g, pc0_w[g], 64'd3);
            chk("gnt_cnt1", g, pc1_w[g], 64'd2);
            chk("wait_cnt", g, pcw_w[g], wcnt[g]);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
